cnt_seg7_disp: RTL and testbench

- Display stage directly downstream of the 8-bit free-running counter.
- Continuously samples the 8-bit count and converts it to three BCD digits with a sequential double-dabble FSM.
- Time-multiplexes the digits onto a 4-digit common-anode 7-segment display.
- Sits between the counter and the board's segment/anode pins.

---
 rtl/cnt_seg7_disp_pkg.sv | 55 +++++
 rtl/cnt_seg7_disp_bin2bcd8.sv | 81 ++++++++
 rtl/cnt_seg7_disp.sv | 111 +++++++++++
 tb/tb_cnt_seg7_disp.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cnt_seg7_disp_pkg.sv
// cnt_seg7_disp_pkg
// Shared definitions for the counter display slice:
//   - conv_state_t : converter FSM states (LOAD -> SHIFT -> DONE)
//   - SEG_*        : active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   - seg_decode   : BCD nibble to segment pattern (non-decimal nibbles blank)
//   - bcd_adjust   : double-dabble "add 3 to every nibble >= 5" step
package cnt_seg7_disp_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [11:0] bcd_adjust(input logic [11:0] bcd);
        logic [11:0] r;
        r = bcd;
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/cnt_seg7_disp_bin2bcd8.sv
// bin2bcd8
// Free-running sequential double-dabble converter, 10 clocks per result:
// LOAD (1) captures bin_in, SHIFT (8) converts, DONE (1) publishes bcd_out.
// Ports:
//   clk     : system clock, posedge
//   rst     : asynchronous reset, active-low
//   bin_in  : 8-bit binary value, sampled only in LOAD
//   bcd_out : {hundreds, tens, ones} display digits, updated at end of DONE
//   done    : high for the single DONE cycle of each conversion
module bin2bcd8
    import cnt_seg7_disp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  bin_in,
    output logic [11:0] bcd_out,
    output logic        done
);

    conv_state_t state, state_nxt;
    logic [7:0]  bin_sr;
    logic [11:0] bcd;
    logic [2:0]  bitcnt;
    logic [19:0] shifted;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= LOAD;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    state_nxt = SHIFT;
            SHIFT:   state_nxt = (bitcnt == 3'd7) ? DONE : SHIFT;
            DONE:    state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Output logic
    always_comb begin
        done = (state == DONE);
    end

    // One double-dabble step: adjust nibbles, then shift {bcd, bin} left.
    always_comb begin
        shifted = {bcd_adjust(bcd), bin_sr} << 1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_sr  <= '0;
            bcd     <= '0;
            bitcnt  <= '0;
            bcd_out <= '0;
        end else begin
            case (state)
                LOAD: begin
                    bin_sr <= bin_in;
                    bcd    <= '0;
                    bitcnt <= '0;
                end
                SHIFT: begin
                    bcd    <= shifted[19:8];
                    bin_sr <= shifted[7:0];
                    bitcnt <= bitcnt + 3'd1;
                end
                DONE: begin
                    bcd_out <= bcd;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cnt_seg7_disp.sv
// cnt_seg7_disp
// Converts the 8-bit counter value to three BCD digits and scans them onto a
// 4-digit common-anode 7-segment display (digit 3 unused).
// Optional build macro: CNT_SEG7_LZ_BLANK_EN enables leading-zero blanking of
// the hundreds and tens digits (ones always shown).
// Parameters:
//   SCAN_DIV : clocks per digit slot (>= 2)
//   DIV_W    : prescaler width, 2**DIV_W >= SCAN_DIV
// Ports:
//   clk       : system clock, posedge
//   rst       : asynchronous reset, active-low
//   cnt_in    : 8-bit count from the counter stage
//   an        : active-low anodes, an[0]=ones an[1]=tens an[2]=hundreds
//   seg       : active-low segments {g,f,e,d,c,b,a}
//   dp        : decimal point, active-low, always off
//   conv_done : one-cycle pulse, new digits latched at the end of it
module cnt_seg7_disp
    import cnt_seg7_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned DIV_W    = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cnt_in,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       conv_done
);

    logic [11:0]      bcd;
    logic [3:0]       d0, d1, d2;
    logic [DIV_W-1:0] presc;
    logic             wrap;
    logic [1:0]       scan_idx, idx_nxt;
    logic [3:0]       digit;
    logic             blank;
    logic [3:0]       an_nxt;
    logic [6:0]       seg_nxt;

    bin2bcd8 u_conv (
        .clk     (clk),
        .rst     (rst),
        .bin_in  (cnt_in),
        .bcd_out (bcd),
        .done    (conv_done)
    );

    assign d0 = bcd[3:0];
    assign d1 = bcd[7:4];
    assign d2 = bcd[11:8];
    assign dp = 1'b1;

    assign wrap = (presc == DIV_W'(SCAN_DIV - 1));

    always_comb begin
        idx_nxt = scan_idx;
        if (wrap)
            idx_nxt = (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
    end

    // an and seg are both driven from idx_nxt so the new digit's pattern
    // appears in the same cycle as its anode (no ghosting).
    always_comb begin
        digit = '0;
        blank = 1'b0;
        an_nxt = '1;
        case (idx_nxt)
            2'd0: begin
                digit  = d0;
                an_nxt = 4'b1110;
            end
            2'd1: begin
                digit  = d1;
                an_nxt = 4'b1101;
`ifdef CNT_SEG7_LZ_BLANK_EN
                blank  = (d2 == 4'd0) && (d1 == 4'd0);
`else
                blank  = 1'b0;
`endif
            end
            2'd2: begin
                digit  = d2;
                an_nxt = 4'b1011;
`ifdef CNT_SEG7_LZ_BLANK_EN
                blank  = (d2 == 4'd0);
`else
                blank  = 1'b0;
`endif
            end
            default: blank = 1'b1;
        endcase
        seg_nxt = blank ? SEG_BLANK : seg_decode(digit);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc    <= '0;
            scan_idx <= '0;
            an       <= '1;
            seg      <= SEG_BLANK;
        end else begin
            presc    <= wrap ? '0 : presc + 1'b1;
            scan_idx <= idx_nxt;
            an       <= an_nxt;
            seg      <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_cnt_seg7_disp.sv
// tb_cnt_seg7_disp
// Scoreboard bench: each sampled count value is queued at its sample cycle;
// a monitor pops one entry per conv_done pulse and checks the scanned display.
module tb_cnt_seg7_disp;

    logic       clk;
    logic       rst;
    logic [7:0] cnt_in;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       conv_done;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned k = 0;      // clock edges since reset release
    int          q[$];       // sampled values awaiting conversion

    cnt_seg7_disp #(.SCAN_DIV(4), .DIV_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .cnt_in    (cnt_in),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .conv_done (conv_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at t=%0t k=%0d: got %0h expected %0h", name, $time, k, act, exp);
        end
    endtask

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int idx);
        int h, t, o;
        bit lz;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
`ifdef CNT_SEG7_LZ_BLANK_EN
        lz = 1'b1;
`else
        lz = 1'b0;
`endif
        case (idx)
            0: return pat(o);
            1: return (lz && h == 0 && t == 0) ? 7'b1111111 : pat(t);
            2: return (lz && h == 0) ? 7'b1111111 : pat(h);
            default: return 7'b1111111;
        endcase
    endfunction

    // Sample tracker: a value is taken on edges 1, 11, 21, ... after release.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                k = 0;
            end else begin
                k++;
                if (k % 10 == 1)
                    q.push_back(int'(cnt_in));
            end
        end
    end

    // Monitor: expected display state derived from popped results.
    initial begin
        int dreg, src, pend, idx;
        bit havep;
        logic [3:0] an_exp;
        dreg = 0; src = 0; pend = 0; havep = 1'b0;
        forever begin
            @(negedge clk);
            check("dp", dp, 1);
            if (!rst || k == 0) begin
                check("an_rst", an, 4'b1111);
                check("seg_rst", seg, 7'b1111111);
                check("done_rst", conv_done, 0);
                q.delete();
                dreg = 0; src = 0; havep = 1'b0;
            end else begin
                idx = (k / 4) % 3;
                an_exp = 4'b1111;
                an_exp[idx] = 1'b0;
                check("an", an, an_exp);
                check("seg", seg, exp_seg(src, idx));
                check("conv_done", conv_done, (k % 10 == 9) ? 1 : 0);
                if (havep) begin
                    dreg  = pend;
                    havep = 1'b0;
                end
                src = dreg;
                if (conv_done) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL conv_q: conv_done with no queued sample, expected none pending");
                    end else begin
                        pend  = q.pop_front();
                        havep = 1'b1;
                    end
                end
            end
        end
    end

    task automatic hold(input logic [7:0] v, input int n);
        cnt_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int r;
        rst = 1'b0;
        cnt_in = 8'd0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;

        hold(8'd0, 30);
        hold(8'd255, 30);
        hold(8'd100, 20);
        hold(8'd9, 20);

        // Reset in the middle of SHIFT with 200 loaded.
        hold(8'd200, 12);
        for (int i = 0; i < 10 && (k % 10) != 5; i++) begin
            @(posedge clk);
            #1;
        end
        check("align_shift", k % 10, 5);
        rst = 1'b0;
        #1;
        check("an_async", an, 4'b1111);
        check("seg_async", seg, 7'b1111111);
        check("done_async", conv_done, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        hold(8'd200, 25);

        // Random values, with extra weight on the range ends.
        repeat (600) begin
            r = int'($urandom_range(0, 7));
            if (r == 0)
                cnt_in = 8'd0;
            else if (r == 1)
                cnt_in = 8'd255;
            else
                cnt_in = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
